score_keeper: RTL

- Parametrised successor to the fixed four-digit BCD score block.
- Single clock domain. Score is a DIGITS-wide BCD counter, updated only on game beat ticks while a game is running.
- Adds a streak-based multiplier, applied as a multi-cycle repeated BCD add, plus saturation and a persistent high score.
- Drives HEX0..HEX5 with either the live score or the high score.

---
 rtl/score_keeper.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// +----------------------------------------------------------------------+
// | score_keeper: parametrised BCD score with streak multiplier,          |
// | saturation, persistent high score and seven-segment display drive.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module score_keeper #(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] POINTS_BCD  = 16'h0010,
    parameter int                  STREAK_STEP = 4,
    parameter int                  MULT_MAX    = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start_n,
    input  logic                  clear_n,
    input  logic                  beat_tick,
    input  logic                  hit,
    input  logic                  miss,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  running,
    output logic                  busy,
    output logic [2:0]            mult,
    output logic                  overflow,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX4,
    output logic [6:0]            HEX5
);

    localparam int              c_W    = 4 * DIGITS;
    localparam logic [c_W-1:0]  c_ALL9 = {DIGITS{4'h9}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    state_t          r_state;
    logic [2:0]      r_remaining;
    logic [7:0]      r_streak;
    logic [c_W-1:0]  r_score;
    logic [c_W-1:0]  r_high;
    logic            r_running;
    logic            r_busy;
    logic            r_overflow;

    logic [1:0]      r_start_sync;
    logic [1:0]      r_clear_sync;
    logic            r_start_prev;
    logic            r_clear_prev;
    logic            w_start_edge;
    logic            w_clear_edge;

    logic [c_W:0]    w_sum;
    logic [8:0]      w_mult_raw;
    logic [2:0]      w_mult;
    logic [c_W-1:0]  w_sel;
    logic [6:0]      w_hex [6];

    function automatic logic [c_W:0] bcd_add(input logic [c_W-1:0] a,
                                             input logic [c_W-1:0] b);
        logic [c_W-1:0] sum;
        logic           carry;
        logic [4:0]     d;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
            if (d > 5'd9) begin
                d     = d - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = d[3:0];
        end
        return {carry, sum};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Keys are raw pins: two-flop synchroniser, then a falling-edge detect.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_start_sync <= 2'b11;
            r_clear_sync <= 2'b11;
            r_start_prev <= 1'b1;
            r_clear_prev <= 1'b1;
        end else begin
            r_start_sync <= {r_start_sync[0], start_n};
            r_clear_sync <= {r_clear_sync[0], clear_n};
            r_start_prev <= r_start_sync[1];
            r_clear_prev <= r_clear_sync[1];
        end
    end

    assign w_start_edge = r_start_prev & ~r_start_sync[1];
    assign w_clear_edge = r_clear_prev & ~r_clear_sync[1];

    assign w_sum      = bcd_add(r_score, POINTS_BCD);
    assign w_mult_raw = 9'd1 + 9'(32'(r_streak) / STREAK_STEP);
    assign w_mult     = (w_mult_raw > 9'(MULT_MAX)) ? 3'(MULT_MAX) : w_mult_raw[2:0];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= 3'd0;
            r_streak    <= 8'd0;
            r_score     <= '0;
            r_high      <= '0;
            r_running   <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_clear_edge) begin
            // BCD digits are weighted like binary nibbles, so a plain compare orders them.
            if (r_score > r_high) begin
                r_high <= r_score;
            end
            r_score     <= '0;
            r_streak    <= 8'd0;
            r_overflow  <= 1'b0;
            r_running   <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
            r_remaining <= 3'd0;
        end else if (w_start_edge && !r_running) begin
            r_score    <= '0;
            r_streak   <= 8'd0;
            r_overflow <= 1'b0;
            r_running  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (beat_tick && r_running) begin
                        if (miss) begin
                            r_streak <= 8'd0;
                        end else if (hit) begin
                            r_streak    <= (r_streak == 8'hFF) ? 8'hFF : r_streak + 8'd1;
                            r_remaining <= w_mult;
                            r_busy      <= 1'b1;
                            r_state     <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    if (w_sum[c_W] || r_overflow) begin
                        r_score    <= c_ALL9;
                        r_overflow <= 1'b1;
                    end else begin
                        r_score <= w_sum[c_W-1:0];
                    end
                    r_remaining <= r_remaining - 3'd1;
                    if (r_remaining == 3'd1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_sel = show_high ? r_high : r_score;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_hex
            logic [6:0] r_seg;
            if (gi < DIGITS) begin : g_digit
                always_ff @(posedge CLOCK_50 or posedge reset) begin
                    if (reset) begin
                        r_seg <= 7'h40;
                    end else begin
                        r_seg <= seg7(w_sel[4*gi +: 4]);
                    end
                end
            end else begin : g_blank
                assign r_seg = 7'h7F;
            end
            assign w_hex[gi] = r_seg;
        end
    endgenerate

    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign running   = r_running;
    assign busy      = r_busy;
    assign mult      = w_mult;
    assign overflow  = r_overflow;
    assign HEX0      = w_hex[0];
    assign HEX1      = w_hex[1];
    assign HEX2      = w_hex[2];
    assign HEX3      = w_hex[3];
    assign HEX4      = w_hex[4];
    assign HEX5      = w_hex[5];

endmodule

`default_nettype wire
